// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MIPS32 multiply/divide unit with HI/LO registers.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring division.
// Each runs one iteration per cycle, and a final FIX cycle applies the
// sign correction. Divide by zero finishes in one cycle via ZDIV.
// Optional build macro EX_MULDIV_FASTMUL_EN replaces the iterative
// multiply with a single-cycle 64-bit product. Divide is unchanged.
module ex_muldiv #(
    parameter int SIZE     = 32,
    parameter int SIZE_FNC = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                op_valid,
    input  logic [SIZE_FNC-1:0] funcion,
    input  logic [SIZE-1:0]     rs_data,
    input  logic [SIZE-1:0]     rt_data,
    output logic                stall,
    output logic                busy,
    output logic [SIZE-1:0]     result,
    output logic [SIZE-1:0]     hi,
    output logic [SIZE-1:0]     lo
);

    localparam int CW = $clog2(SIZE);
    localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 1);

    localparam logic [SIZE_FNC-1:0] F_MFHI  = SIZE_FNC'('h10);
    localparam logic [SIZE_FNC-1:0] F_MTHI  = SIZE_FNC'('h11);
    localparam logic [SIZE_FNC-1:0] F_MFLO  = SIZE_FNC'('h12);
    localparam logic [SIZE_FNC-1:0] F_MTLO  = SIZE_FNC'('h13);
    localparam logic [SIZE_FNC-1:0] F_MULT  = SIZE_FNC'('h18);
    localparam logic [SIZE_FNC-1:0] F_MULTU = SIZE_FNC'('h19);
    localparam logic [SIZE_FNC-1:0] F_DIV   = SIZE_FNC'('h1A);
    localparam logic [SIZE_FNC-1:0] F_DIVU  = SIZE_FNC'('h1B);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_ZDIV
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic [SIZE-1:0] hi_q, hi_d;
    logic [SIZE-1:0] lo_q, lo_d;
    // Working register: {partial product} for multiply, {remainder, quotient} for divide.
    logic [2*SIZE-1:0] acc_q, acc_d;
    // Multiplicand or divisor magnitude.
    logic [SIZE-1:0] opb_q, opb_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic            is_div_q, is_div_d;

    logic            md_class;
    logic            accept;
    logic            is_signed;
    logic            rs_neg, rt_neg;
    logic [SIZE-1:0] rs_mag, rt_mag;

    logic [SIZE:0]     mul_sum;
    logic [2*SIZE-1:0] mul_next;
    logic [SIZE:0]     div_shift;
    logic [SIZE+1:0]   div_diff;
    logic              div_ge;
    logic [2*SIZE-1:0] div_next;

    logic [2*SIZE-1:0] prod_fix;
    logic [SIZE-1:0]   quo_fix, rem_fix;

    // Decode, operand magnitudes, and the handshake seen by the hazard logic
    always_comb begin
        md_class  = op_valid && (funcion inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                                 F_MULT, F_MULTU, F_DIV, F_DIVU});
        accept    = md_class && !busy_q;
        stall     = md_class && busy_q;
        is_signed = (funcion == F_MULT) || (funcion == F_DIV);
        rs_neg    = is_signed && rs_data[SIZE-1];
        rt_neg    = is_signed && rt_data[SIZE-1];
        rs_mag    = rs_neg ? (~rs_data + 1'b1) : rs_data;
        rt_mag    = rt_neg ? (~rt_data + 1'b1) : rt_data;
    end

    // MFHI/MFLO read the architectural registers with no wait cycle
    always_comb begin
        result = '0;
        if (op_valid && !busy_q) begin
            if (funcion == F_MFHI) result = hi_q;
            else if (funcion == F_MFLO) result = lo_q;
        end
    end

    // One shift-add step and one restoring-divide step, plus the final sign fix
    always_comb begin
        // Multiply: add the multiplicand when the low bit is set, then shift right with carry.
        mul_sum  = {1'b0, acc_q[2*SIZE-1:SIZE]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[SIZE-1:1]};
        // Divide: shift the next dividend bit into the remainder and trial-subtract.
        div_shift = {acc_q[2*SIZE-1:SIZE], acc_q[SIZE-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
        div_ge    = !div_diff[SIZE+1];
        div_next  = {(div_ge ? div_diff[SIZE-1:0] : div_shift[SIZE-1:0]),
                     acc_q[SIZE-2:0], div_ge};
        prod_fix  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix   = neg_res_q ? (~acc_q[SIZE-1:0] + 1'b1) : acc_q[SIZE-1:0];
        rem_fix   = neg_rem_q ? (~acc_q[2*SIZE-1:SIZE] + 1'b1) : acc_q[2*SIZE-1:SIZE];
    end

    // Next-state logic for the FSM, counter, working registers and HI/LO
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (funcion)
                        F_MTHI: hi_d = rs_data;
                        F_MTLO: lo_d = rs_data;
                        F_MULT, F_MULTU: begin
                            busy_d    = 1'b1;
                            cnt_d     = '0;
                            is_div_d  = 1'b0;
`ifdef EX_MULDIV_FASTMUL_EN
                            // Sign-extended operands give the signed product in the low 2*SIZE bits.
                            acc_d     = {{SIZE{rs_neg}}, rs_data} * {{SIZE{rt_neg}}, rt_data};
                            neg_res_d = 1'b0;
                            state_d   = S_FIX;
`else
                            acc_d     = {{SIZE{1'b0}}, rt_mag};
                            opb_d     = rs_mag;
                            neg_res_d = rs_neg ^ rt_neg;
                            state_d   = S_MUL;
`endif
                        end
                        F_DIV, F_DIVU: begin
                            busy_d = 1'b1;
                            cnt_d  = '0;
                            if (rt_data == '0) begin
                                // Keep the raw dividend; it becomes HI unchanged.
                                acc_d   = {{SIZE{1'b0}}, rs_data};
                                state_d = S_ZDIV;
                            end else begin
                                acc_d     = {{SIZE{1'b0}}, rs_mag};
                                opb_d     = rt_mag;
                                neg_res_d = rs_neg ^ rt_neg;
                                neg_rem_d = rs_neg;
                                is_div_d  = 1'b1;
                                state_d   = S_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*SIZE-1:SIZE];
                    lo_d = prod_fix[SIZE-1:0];
                end
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ZDIV: begin
                hi_d    = acc_q[SIZE-1:0];
                lo_d    = '1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases plus random
// mult/div ops, compared against a plain-arithmetic HI/LO model.
module tb_ex_muldiv;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

`ifdef EX_MULDIV_FASTMUL_EN
    localparam int MUL_CYC = 1;
`else
    localparam int MUL_CYC = 33;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [5:0]  funcion;
    logic [31:0] rs_data, rt_data;
    logic        stall, busy;
    logic [31:0] result, hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    always #5 clk = ~clk;

    ex_muldiv #(.SIZE(32), .SIZE_FNC(6)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .funcion(funcion),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .busy(busy),
        .result(result), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural result of one mult/div, straight from integer arithmetic.
    task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output int cyc);
        longint      sa, sb;
        logic [63:0] p, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        eh = '0; el = '0; cyc = 0;
        case (f)
            F_MULT:  begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; cyc = MUL_CYC; end
            F_MULTU: begin p = ua * ub;      eh = p[63:32]; el = p[31:0]; cyc = MUL_CYC; end
            default: begin
                if (b == 0) begin
                    eh = a; el = 32'hFFFF_FFFF; cyc = 1;
                end else if (f == F_DIV) begin
                    p = 64'(sa % sb); eh = p[31:0];
                    p = 64'(sa / sb); el = p[31:0];
                    cyc = 33;
                end else begin
                    p = ua % ub; eh = p[31:0];
                    p = ua / ub; el = p[31:0];
                    cyc = 33;
                end
            end
        endcase
    endtask

    task automatic run_op(input string tag, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int          cyc, n;
        model(f, a, b, eh, el, cyc);
        @(negedge clk);
        op_valid = 1'b1; funcion = f; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        // Scramble operands: the in-flight op must use its latched copies.
        op_valid = 1'b0; funcion = 6'($urandom); rs_data = $urandom; rt_data = $urandom;
        chk({tag, "_hi_hold"}, hi, m_hi);
        chk({tag, "_lo_hold"}, lo, m_lo);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'(cyc));
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        m_hi = eh; m_lo = el;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  f;
        logic [31:0] a, b;
        rst_n = 1'b0; op_valid = 1'b0; funcion = '0; rs_data = '0; rt_data = '0;
        #12;
        op_valid = 1'b1; funcion = F_MULT;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        op_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Directed corner cases
        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_neg",  F_MULT,  32'hFFFF_FFFD, 32'h0000_0007);
        run_op("div_neg",   F_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
        run_op("divu_zero", F_DIVU,  32'h0000_0064, 32'h0000_0000);
        run_op("div_zero",  F_DIV,   32'h8000_0005, 32'h0000_0000);
        run_op("div_ovf",   F_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mult_min",  F_MULT,  32'h8000_0000, 32'h8000_0000);
        run_op("divu_big",  F_DIVU,  32'hFFFF_FFFF, 32'h0000_0003);

        // Back-to-back MULTU then MFLO: stall for the whole op, then no bubble
        @(negedge clk);
        op_valid = 1'b1; funcion = F_MULTU; rs_data = 32'd6; rt_data = 32'd7;
        @(posedge clk); #1;
        funcion = F_MFLO; rs_data = $urandom; rt_data = $urandom;
        for (int i = 0; i < MUL_CYC; i++) begin
            chk("mflo_stall_hi", {31'b0, stall}, 32'd1);
            @(posedge clk); #1;
        end
        chk("mflo_stall_lo", {31'b0, stall}, 32'd0);
        chk("mflo_result", result, 32'h0000_002A);
        m_hi = 32'd0; m_lo = 32'h2A;

        // MTLO then MFLO/MFHI in the following cycle
        @(negedge clk);
        funcion = F_MTLO; rs_data = 32'd5;
        @(posedge clk); #1;
        funcion = F_MFLO;
        #1 chk("mtlo_mflo", result, 32'd5);
        funcion = F_MTHI; rs_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        funcion = F_MFHI;
        #1 chk("mthi_mfhi", result, 32'hDEAD_BEEF);
        m_hi = 32'hDEAD_BEEF; m_lo = 32'd5;
        op_valid = 1'b0;

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        op_valid = 1'b1; funcion = F_DIV; rs_data = 32'h1234_5678; rt_data = 32'd13;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        op_valid = 1'b1; funcion = F_DIV;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_stall", {31'b0, stall}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        op_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        m_hi = '0; m_lo = '0;
        run_op("post_rst_multu", F_MULTU, $urandom, $urandom);

        // Random mult/div mix with occasional zero divisors and extreme values
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(3))
                0: f = F_MULT;
                1: f = F_MULTU;
                2: f = F_DIV;
                default: f = F_DIVU;
            endcase
            a = $urandom;
            b = $urandom;
            case ($urandom_range(7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(15));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op("rand", f, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit for the MIPS32 EX stage, fed by the ID/EX pipeline register outputs (decoded funct field plus the rs/rt operands). It executes MULT, MULTU, DIV and DIVU over multiple cycles into architectural HI/LO registers, and serves MFHI/MFLO/MTHI/MTLO. While an operation is in flight it raises `stall`, and the hazard logic holds IF/ID and ID/EX on that signal. Results feed the EX/MEM register through `result`.

## Interface
- `SIZE`, 32, operand, HI and LO width
- `SIZE_FNC`, 6, funct field width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `op_valid`  in  1  EX-stage instruction is R-type and `funcion` is meaningful
- `funcion`  in  SIZE_FNC  funct field from ID/EX
- `rs_data`  in  SIZE  rs operand; dividend or multiplicand; source for MTHI/MTLO
- `rt_data`  in  SIZE  rt operand; divisor or multiplier
- `stall`  out  1  hold upstream stages; combinational
- `busy`  out  1  mult/div operation in flight; registered
- `result`  out  SIZE  HI for MFHI, LO for MFLO, otherwise 0; combinational
- `hi`, `lo`  out  SIZE  architectural HI/LO registers

## Operation
- Funct codes:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B
  - Every other funct is ignored.
- An instruction is "muldiv-class" when `op_valid` is high and `funcion` is one of the eight codes above.
- `stall = busy & muldiv-class`. A stalled instruction has no effect; it is re-presented on a later cycle.
- Accept condition: muldiv-class and `!busy`.
  - MTHI/MTLO: write `rs_data` into HI/LO at that edge.
  - MFHI/MFLO: return the current HI/LO combinationally on `result`, with no wait cycle.
- States:
  - IDLE: accepting MULT* moves to MUL; accepting DIV* moves to DIV. Accepting DIV* with `rt_data==0` moves to ZDIV.
  - MUL and DIV: 32 iterations, one per cycle, counted by a 5-bit counter. After the last iteration the state moves to FIX.
  - FIX: applies sign correction, writes HI/LO, and returns to IDLE.
  - ZDIV: writes HI=`rs_data` (latched) and LO=0xFFFFFFFF, then returns to IDLE. This applies to both signed and unsigned divide.
- Signed ops: magnitudes are latched at accept, together with the result sign (xor of operand signs) and the remainder sign (dividend sign).
- Multiply: radix-2 shift-add over the 64-bit product {HI,LO}.
- Divide: restoring division. Quotient goes to LO, remainder to HI. The remainder takes the dividend's sign.
- 0x80000000 / -1 (signed): LO=0x80000000, HI=0. No trap.
- Operands are latched at accept; later changes on `rs_data`/`rt_data` have no effect on an in-flight op.
- HI/LO are never partially visible: both update only in the FIX or ZDIV cycle.
- Reset: asynchronous; clears state to IDLE, counter to 0, HI=LO=0 and busy=0, so `stall`=0. A reset mid-operation discards the operation.

## Timing
- Edge N accepts MULT*/DIV*. `busy` rises after edge N.
- Edges N+1..N+32 perform the iterations.
- Edge N+33 (FIX) writes HI/LO and clears `busy`.
- `busy` is high for 33 cycles; new HI/LO are visible from the cycle after edge N+33.
- Divide by zero: edge N+1 writes HI/LO; `busy` is high for 1 cycle.
- MTHI/MTLO: HI/LO update at the accept edge. An MFHI/MFLO in the next cycle sees the new value.
- A MULT/DIV arriving while busy stalls. It is accepted in the cycle after `busy` falls, with no bubble.
- `result` and `stall` have zero latency (combinational from inputs and registered state).

## Configuration
- `EX_MULDIV_FASTMUL_EN` defined: MULT/MULTU use a single-cycle 64-bit product.
  - The signed product comes from sign-extended operands.
  - IDLE moves to FIX directly; HI/LO are written at edge N+1 and `busy` is high for 1 cycle.
  - Divide is unchanged.
- Undefined: iterative multiply as specified above, with 33 busy cycles.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `busy` high for 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD × 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 0x00000064 / 0 -> `busy` high for 1 cycle, then HI=0x00000064, LO=0xFFFFFFFF.
- MULTU 6×7 followed immediately by MFLO:
  - `stall` stays high for the 33 busy cycles.
  - In the next cycle `stall`=0 and `result`=0x0000002A.
  - MTLO 0x5 followed by MFLO -> `result`=0x5.
- Deassert `rst_n` at iteration 10 of a DIV -> `busy`=0, `stall`=0, HI=LO=0 immediately (no clock edge needed). A new MULTU after reset completes correctly.
